aes_inv_round_ctrl: RTL
=======================

# aes_inv_round_ctrl

Sequencer for the byte-serial inverse AES round datapath (`aes_inv_rounddata`). It accepts one 128-bit ciphertext block and a key-size mode, then walks the datapath through rounds 0..Nr at one byte per cycle. It requests round keys and holds the 128-bit round state register that feeds the datapath's `data_in`, and returns the plaintext over a valid/ready handshake. It sits between the block-level host interface and one `aes_inv_rounddata` instance plus the key store.

## Interface
Parameters:
- `BEATS`, 16: bytes per round; `width_sel` counts 0..BEATS-1.
- `KIDX_W`, 4: width of the round-key index.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  ciphertext block offered.
- `in_ready`  out  1  controller idle, block can be accepted.
- `in_data`  in  128  ciphertext.
- `in_mode`  in  2  00 = AES128, 01 = AES192, 10 = AES256, 11 = reserved.
- `out_valid`  out  1  plaintext available.
- `out_ready`  in  1  consumer accepts plaintext.
- `out_data`  out  128  plaintext (the state register).
- `mode_err`  out  1  one-cycle pulse: block rejected because `in_mode`=11.
- `key_idx`  out  KIDX_W  round key requested, equal to Nr − round.
- `key_valid`  in  1  the key store presents the key for `key_idx` this cycle.
- `dp_round`  out  4  drives datapath `round`.
- `dp_mode`  out  2  drives datapath `mode` (latched at accept).
- `dp_width_sel`  out  4  drives datapath `width_sel`.
- `dp_data_in`  out  128  drives datapath `data_in` (the state register).
- `dp_data_out`  in  128  datapath `data_out`.
- `dp_en`  out  1  datapath advance enable; high only on active beats.
- `abort`  in  1  present only with AES_INV_CTRL_ABORT_EN.

## Operation
- States: IDLE, RUN, WAIT_KEY, DONE.
- IDLE: `in_ready`=1.
  - On `in_valid & in_ready` with mode ≠ 11: latch `in_data` into the state register, latch the mode, set round=0 and beat=0, go to RUN.
  - On mode 11: drop the block, pulse `mode_err`, stay in IDLE.
- Nr = 10/12/14 for mode 00/01/10.
- RUN, each cycle with `key_valid`=1 (active beat):
  - `dp_en`=1.
  - beat increments modulo BEATS.
  - At beat = BEATS−1: state register <= `dp_data_out`, beat <= 0.
    - If round = Nr, go to DONE.
    - Otherwise round increments.
- RUN with `key_valid`=0: go to WAIT_KEY. Beat, round and state hold, and `dp_en`=0.
- WAIT_KEY: hold everything. The first cycle with `key_valid`=1 is an active beat, and the controller returns to RUN.
- DONE: `out_valid`=1 and `out_data` = state register, both held stable until `out_ready`. On the handshake, go to IDLE. `in_ready` rises the next cycle; there is no overlap with the next block.
- `key_idx` = Nr − round, combinational from registered round and mode.
- `dp_width_sel` = beat; `dp_round` = round.
- `out_data` is always driven by the state register. It is meaningful only while `out_valid`=1.
- Reset values: state IDLE, `in_ready`=1 once reset deasserts, `out_valid`=0, `mode_err`=0, `dp_en`=0, round=0, beat=0, mode=00, state register all zeros.
- `rst_n` asserted mid-block discards the block immediately; no output is produced.

## Timing
- Accept at cycle T: first active beat is T+1 with round=0 and `width_sel`=0.
- With `key_valid` held high, `out_valid` rises at T + 16·(Nr+1) + 1, i.e. T+177, T+209 or T+241 for mode 00, 01 or 10.
- Each cycle of `key_valid`=0 inside RUN/WAIT_KEY adds exactly one cycle of latency.
- The state register updates only on beat BEATS−1 of an active cycle.
- `out_valid` and `out_ready` high in the same cycle complete the transfer in that cycle.
- `in_valid` has no effect outside IDLE.

## Configuration
- `AES_INV_CTRL_ABORT_EN` defined:
  - `abort` port exists.
  - `abort`=1 in any state forces IDLE on the next edge and clears `out_valid`, `dp_en`, round and beat.
  - `abort` takes priority over a simultaneous `in_valid` or `out_ready`.
- Undefined: no `abort` port; blocks always run to completion.

## Structure
- Shared package `aes_pkg` holds:
  - the mode encoding constants;
  - the Nr lookup function (mode → 10/12/14);
  - the controller state enum.
- One sub-module, `aes_round_beat_cnt`: the beat/round counter with enable, wrap at BEATS−1, a terminal-round compare and a round-done strobe.

## Test plan
- Reset with `rst_n`=0 mid-RUN → next cycle is IDLE, `out_valid`=0, `in_ready`=1 after release, no output produced.
- FIPS-197 AES128 vector (ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, `key_valid`=1) → plaintext 00112233445566778899aabbccddeeff with `out_valid` at T+177; `key_idx` sequence 10..0.
- AES256 FIPS vector with `key_valid` dropped for 3 cycles at round 5, beat 7 → correct plaintext at T+244; beat and round frozen during the stall.
- `in_mode`=11 with `in_valid`=1 → `mode_err` pulses for 1 cycle, `in_ready` stays 1, `out_valid` never rises.
- DONE with `out_ready`=0 for 10 cycles → `out_data` stable; `in_valid` ignored until the handshake; IDLE the next cycle.
- (ABORT_EN) `abort` at round 3 → IDLE the next cycle; a following AES192 block decrypts correctly at T+209.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the inverse AES round controller: mode encodings,
// round-count lookup and the controller state type.
package aes_pkg;

    localparam logic [1:0] MODE_AES128 = 2'b00;
    localparam logic [1:0] MODE_AES192 = 2'b01;
    localparam logic [1:0] MODE_AES256 = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT_KEY,
        ST_DONE
    } ctrl_state_e;

    // Number of rounds (Nr) for a key-size mode; the reserved code never reaches here.
    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        logic [3:0] nr;
        case (mode)
            MODE_AES128: nr = 4'd10;
            MODE_AES192: nr = 4'd12;
            default:     nr = 4'd14;
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/aes_inv_round_ctrl_if.sv
// Host-side block interface of the inverse AES round controller:
// ciphertext in, plaintext out, each on a valid/ready handshake.
interface aes_inv_round_ctrl_if;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         mode_err;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, mode_err
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, mode_err
    );

endinterface

// File: rtl/aes_round_beat_cnt.sv
// Beat/round counter for the byte-serial inverse round: beat wraps at BEATS-1,
// round advances on each wrap until it reaches the terminal round nr.
module aes_round_beat_cnt #(
    parameter int unsigned BEATS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [3:0] nr,
    output logic [3:0] beat,
    output logic [3:0] round,
    output logic       last_beat,
    output logic       last_round,
    output logic       round_done
);

    localparam logic [3:0] BEAT_MAX = 4'(BEATS - 1);

    assign last_beat  = (beat == BEAT_MAX);
    assign last_round = (round == nr);
    assign round_done = en & last_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat  <= '0;
            round <= '0;
        end else if (clr) begin
            beat  <= '0;
            round <= '0;
        end else if (en) begin
            if (last_beat) begin
                beat <= '0;
                // round stays at nr on the final wrap; the controller leaves RUN there
                if (!last_round) begin
                    round <= round + 4'd1;
                end
            end else begin
                beat <= beat + 4'd1;
            end
        end
    end

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Sequencer for the byte-serial inverse AES round datapath; holds the round state.
// Optional AES_INV_CTRL_ABORT_EN adds an abort input that returns to IDLE.
module aes_inv_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned BEATS  = 16,
    parameter int unsigned KIDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_inv_round_ctrl_if.slave  host,
    output logic [KIDX_W-1:0]    key_idx,
    input  logic                 key_valid,
    output logic [3:0]           dp_round,
    output logic [1:0]           dp_mode,
    output logic [3:0]           dp_width_sel,
    output logic [127:0]         dp_data_in,
    input  logic [127:0]         dp_data_out,
    output logic                 dp_en
`ifdef AES_INV_CTRL_ABORT_EN
    ,
    input  logic                 abort
`endif
);

    ctrl_state_e  state_q, state_d;
    logic [1:0]   mode_q;
    logic [127:0] data_q;
    logic         mode_err_q;

    logic         abort_w;
    logic         in_run;
    logic         active;
    logic         accept;
    logic         reject;
    logic [3:0]   nr;
    logic [3:0]   beat, round;
    logic [3:0]   key_diff;
    logic         last_beat, last_round, round_done;

`ifdef AES_INV_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign nr     = nr_of(mode_q);
    assign in_run = (state_q == ST_RUN) || (state_q == ST_WAIT_KEY);
    // abort outranks every other request in the same cycle
    assign active = in_run && key_valid && !abort_w;
    assign accept = (state_q == ST_IDLE) && host.in_valid && (host.in_mode != MODE_RSVD) && !abort_w;
    assign reject = (state_q == ST_IDLE) && host.in_valid && (host.in_mode == MODE_RSVD) && !abort_w;

    aes_round_beat_cnt #(
        .BEATS (BEATS)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (accept | abort_w),
        .en         (active),
        .nr         (nr),
        .beat       (beat),
        .round      (round),
        .last_beat  (last_beat),
        .last_round (last_round),
        .round_done (round_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_RUN;
            end
            ST_RUN, ST_WAIT_KEY: begin
                // a WAIT_KEY cycle that sees the key is itself an active beat
                if (!key_valid)                    state_d = ST_WAIT_KEY;
                else if (round_done && last_round) state_d = ST_DONE;
                else                               state_d = ST_RUN;
            end
            ST_DONE: begin
                if (host.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_w) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_AES128;
            data_q     <= '0;
            mode_err_q <= 1'b0;
        end else begin
            mode_err_q <= reject;
            if (accept) begin
                mode_q <= host.in_mode;
                data_q <= host.in_data;
            end else if (active && last_beat) begin
                data_q <= dp_data_out;
            end
        end
    end

    assign key_diff       = nr - round;
    assign key_idx        = KIDX_W'(key_diff);
    assign dp_round       = round;
    assign dp_width_sel   = beat;
    assign dp_mode        = mode_q;
    assign dp_data_in     = data_q;
    assign dp_en          = active;

    assign host.in_ready  = (state_q == ST_IDLE);
    assign host.out_valid = (state_q == ST_DONE);
    assign host.out_data  = data_q;
    assign host.mode_err  = mode_err_q;

endmodule
